// File: rtl/bus_arb.sv
// -----------------------------------------------------------------------------
// bus_arb -- two-master arbiter for the 16 MB RISC5 system bus.
//
// Grants the single slave-side bus (address decoder: PROM, RAM, I/O) to one
// master for one complete strobe/acknowledge transaction at a time. Contending
// masters are served round-robin. One idle cycle always separates two
// transactions.
//
// Optional feature (compile-time macro BUS_ARB_TIMEOUT_EN):
//   A granted transaction still waiting for s_ack after TIMEOUT cycles is
//   terminated by the arbiter. The master gets an ack with zero read data, and
//   the sticky bus_err flag is set. Without the macro there is no counter,
//   bus_err is tied to 0, err_clr is ignored, and a transaction waits for
//   s_ack indefinitely.
//
// Parameters
//   TIMEOUT   cycles a granted transaction may wait for s_ack (1..255)
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   m0_stb/we/addr/dout -> m0_din/ack   master 0 (CPU)
//   m1_stb/we/addr/dout -> m1_din/ack   master 1 (DMA / video fetch)
//   s_stb/we/addr/dout  <- s_din/ack    slave side toward the address decoder
//   grant    one-hot owner: 01 master 0, 10 master 1, 00 idle
//   bus_err  sticky timeout flag, cleared by an err_clr pulse
// -----------------------------------------------------------------------------
module bus_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [21:0] m0_addr,
  input  logic [31:0] m0_dout,
  output logic [31:0] m0_din,
  output logic        m0_ack,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [21:0] m1_addr,
  input  logic [31:0] m1_dout,
  output logic [31:0] m1_din,
  output logic        m1_ack,
  output logic        s_stb,
  output logic        s_we,
  output logic [21:0] s_addr,
  output logic [31:0] s_dout,
  input  logic [31:0] s_din,
  input  logic        s_ack,
  output logic [1:0]  grant,
  output logic        bus_err,
  input  logic        err_clr
);

  // The state encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS0 = 2'b01,
    BUS1 = 2'b10
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;      // last master served; 1 favours master 0

  // Fields of whichever master currently owns the bus.
  logic        own_sel;        // 1 when master 1 owns the bus
  logic        own_stb;
  logic        own_we;
  logic [21:0] own_addr;
  logic [31:0] own_dout;

  // Acknowledge and read data for the owning master before steering.
  logic        tx_ack;
  logic [31:0] tx_din;

  logic        timeout_reached; // wait limit reached in this granted cycle
  logic        timeout_hit;     // forced termination happening this cycle

  always_comb begin
    own_sel  = (state_q == BUS1);
    own_stb  = own_sel ? m1_stb  : m0_stb;
    own_we   = own_sel ? m1_we   : m0_we;
    own_addr = own_sel ? m1_addr : m0_addr;
    own_dout = own_sel ? m1_dout : m0_dout;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave a value held (no inferred latches).
    state_d     = state_q;
    last_d      = last_q;
    s_stb       = 1'b0;
    s_we        = 1'b0;
    s_addr      = '0;
    s_dout      = '0;
    tx_ack      = 1'b0;
    tx_din      = '0;
    timeout_hit = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On a tie, master 0 wins only if master 1 was served last.
        if (m0_stb && (!m1_stb || last_q)) begin
          state_d = BUS0;
        end else if (m1_stb) begin
          state_d = BUS1;
        end
      end

      BUS0, BUS1: begin
        s_we   = own_we;
        s_addr = own_addr;
        s_dout = own_dout;
        if (!own_stb) begin
          // Owner withdrew its strobe: release the bus without an ack and
          // without moving the round-robin pointer.
          state_d = IDLE;
        end else begin
          s_stb  = 1'b1;
          tx_ack = s_ack;
          tx_din = s_din;
          if (s_ack) begin
            state_d = IDLE;
            last_d  = own_sel;
          end else if (timeout_reached) begin
            // Arbiter answers in place of the silent slave.
            s_stb       = 1'b0;
            tx_ack      = 1'b1;
            tx_din      = '0;
            timeout_hit = 1'b1;
            state_d     = IDLE;
            last_d      = own_sel;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Only the owner ever sees an ack or read data; the other master reads 0.
  assign m0_ack = tx_ack & ~own_sel;
  assign m0_din = own_sel ? '0 : tx_din;
  assign m1_ack = tx_ack & own_sel;
  assign m1_din = own_sel ? tx_din : '0;
  assign grant  = 2'(state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] TimeoutLim = TIMEOUT[7:0];

  logic [7:0] cnt_q, cnt_d;
  logic       bus_err_q, bus_err_d;

  assign timeout_reached = (cnt_q == TimeoutLim);

  always_comb begin
    // Counting only while the transaction stays granted means the counter is
    // already 0 whenever a new grant starts.
    cnt_d = '0;
    if ((state_q != IDLE) && (state_d == state_q)) begin
      cnt_d = cnt_q + 8'd1;
    end

    // A timeout in the same cycle as err_clr takes precedence.
    bus_err_d = bus_err_q;
    if (err_clr) begin
      bus_err_d = 1'b0;
    end
    if (timeout_hit) begin
      bus_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign timeout_reached = 1'b0;
  assign bus_err         = 1'b0;

  // Inputs and parameters that only matter with the timeout feature.
  logic unused_cfg;
  assign unused_cfg = err_clr ^ timeout_hit ^ (TIMEOUT == 32'd0);
`endif

endmodule
